// File: rtl/lupa_cfg_scheduler.sv
// ---------------------------------------------------------------------------
// lupa_cfg_scheduler
//
// Shadow register file and upload scheduler for the 16 x 12-bit LUPA300
// configuration registers. Host writes land in the shadow and mark the
// register dirty. Dirty registers are uploaded only during the inter-frame
// gap (fval low): after GUARD_CYCLES consecutive synchronised fval-low
// cycles, one {index, data} word at a time goes to the SPI shifter, lowest
// index first, over a req/ack handshake. The sensor is never reprogrammed
// mid-frame.
//
// Ports
//   clock_20     in   1   system clock, rising edge
//   reset_p      in   1   asynchronous active-high reset
//   fval         in   1   sensor frame valid (asynchronous, synchronised here)
//   host_wr      in   1   single-cycle shadow write strobe
//   host_addr    in   4   shadow register index for host_wr
//   host_data    in   12  shadow write data
//   init_req     in   1   single-cycle pulse: mark all registers dirty
//   rd_addr      in   4   readback index
//   rd_data      out  12  shadow[rd_addr], combinational
//   spi_req      out  1   word valid to shifter (registered)
//   spi_word     out  16  {index, data}, stable while spi_req is high
//   spi_ack      in   1   single-cycle pulse: word shifted and latched
//   dirty        out  16  per-register pending flags
//   busy         out  1   high whenever the scheduler is not idle
//   upload_done  out  1   single-cycle pulse: last dirty register acknowledged
// ---------------------------------------------------------------------------
module lupa_cfg_scheduler #(
    parameter int GUARD_CYCLES = 4
) (
    input  logic        clock_20,
    input  logic        reset_p,
    input  logic        fval,
    input  logic        host_wr,
    input  logic [3:0]  host_addr,
    input  logic [11:0] host_data,
    input  logic        init_req,
    input  logic [3:0]  rd_addr,
    output logic [11:0] rd_data,
    output logic        spi_req,
    output logic [15:0] spi_word,
    input  logic        spi_ack,
    output logic [15:0] dirty,
    output logic        busy,
    output logic        upload_done
);

    localparam int GCNT_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_SCAN  = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
    logic [11:0]         shadow_q [16];
    logic [15:0]         dirty_q, dirty_d;
    logic                spi_req_q, spi_req_d;
    logic [15:0]         spi_word_q, spi_word_d;
    logic                done_q, done_d;
    logic                fval_meta_q, fval_s_q;

    logic [15:0]         set_mask;
    logic [15:0]         clr_mask;
    logic [15:0]         dirty_hold;
    logic [3:0]          scan_idx;

    // Sensor power-up defaults for each configuration register.
    function automatic logic [11:0] shadow_default(input logic [3:0] idx);
        logic [11:0] v;
        case (idx)
            4'h0:    v = 12'h029;
            4'h3:    v = 12'h0A0;
            4'h4:    v = 12'h002;
            4'h7:    v = 12'h1E1;
            4'h8:    v = 12'h04A;
            4'h9:    v = 12'h06B;
            4'hA:    v = 12'h055;
            4'hB:    v = 12'h0F0;
            4'hC:    v = 12'hFB0;
            4'hD:    v = 12'hADF;
            4'hE:    v = 12'h6DB;
            4'hF:    v = 12'h0DB;
            default: v = 12'h000;
        endcase
        return v;
    endfunction

    // Priority encoder: index 0 has the highest priority.
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Stage boundary: fval crosses into the clock_20 domain through two flops.
    // They reset to 1 so nothing uploads until a genuine low has been seen.
    always_ff @(posedge clock_20 or posedge reset_p) begin
        if (reset_p) begin
            fval_meta_q <= 1'b1;
            fval_s_q    <= 1'b1;
        end else begin
            fval_meta_q <= fval;
            fval_s_q    <= fval_meta_q;
        end
    end

    // Shadow register file; host writes are accepted in every state.
    always_ff @(posedge clock_20 or posedge reset_p) begin
        if (reset_p) begin
            for (int i = 0; i < 16; i++) begin
                shadow_q[i] <= shadow_default(4'(i));
            end
        end else if (host_wr) begin
            shadow_q[host_addr] <= host_data;
        end
    end

    assign rd_data = shadow_q[rd_addr];

    always_comb begin
        set_mask = 16'h0000;
        if (init_req) set_mask = 16'hFFFF;
        if (host_wr)  set_mask = set_mask | (16'h0001 << host_addr);
    end

    // Dirty state as it will stand if nothing is cleared this cycle; used to
    // decide on completion so a same-cycle host write keeps the upload going.
    assign dirty_hold = dirty_q | set_mask;
    assign scan_idx   = lowest_set(dirty_q);

    always_comb begin
        state_d    = state_q;
        gcnt_d     = gcnt_q;
        spi_req_d  = spi_req_q;
        spi_word_d = spi_word_q;
        done_d     = 1'b0;
        clr_mask   = 16'h0000;

        case (state_q)
            ST_IDLE: begin
                if (!fval_s_q && (dirty_q != 16'h0000)) begin
                    state_d = ST_GUARD;
                    gcnt_d  = '0;
                end
            end

            ST_GUARD: begin
                if (fval_s_q || (dirty_q == 16'h0000)) begin
                    state_d = ST_IDLE;
                end else if (gcnt_q == GCNT_W'(GUARD_CYCLES - 1)) begin
                    state_d = ST_SCAN;
                end else begin
                    gcnt_d = gcnt_q + GCNT_W'(1);
                end
            end

            ST_SCAN: begin
                if (fval_s_q || (dirty_q == 16'h0000)) begin
                    state_d = ST_IDLE;
                end else begin
                    // The word carries the pre-write value; a same-cycle host
                    // write re-sets the dirty bit so the new value follows.
                    spi_word_d = {scan_idx, shadow_q[scan_idx]};
                    clr_mask   = 16'h0001 << scan_idx;
                    spi_req_d  = 1'b1;
                    state_d    = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (spi_ack) begin
                    spi_req_d = 1'b0;
                    if (dirty_hold == 16'h0000) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (!fval_s_q) begin
                        // Still inside the same gap: no new guard interval.
                        state_d = ST_SCAN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d   = ST_IDLE;
                spi_req_d = 1'b0;
            end
        endcase

        // Sets win over a same-cycle clear.
        dirty_d = (dirty_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clock_20 or posedge reset_p) begin
        if (reset_p) begin
            state_q    <= ST_IDLE;
            gcnt_q     <= '0;
            dirty_q    <= 16'hFFFF;
            spi_req_q  <= 1'b0;
            spi_word_q <= 16'h0000;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gcnt_q     <= gcnt_d;
            dirty_q    <= dirty_d;
            spi_req_q  <= spi_req_d;
            spi_word_q <= spi_word_d;
            done_q     <= done_d;
        end
    end

    assign spi_req     = spi_req_q;
    assign spi_word    = spi_word_q;
    assign dirty       = dirty_q;
    assign busy        = (state_q != ST_IDLE);
    assign upload_done = done_q;

endmodule
